// File: rtl/alu_rr_sequencer.sv
// Hardwired control sequencer for register-register ALU instructions (T0..T5).
// Adds memory-ready wait states in T1 and traps opcodes not set in LEGAL_MASK.
module alu_rr_sequencer #(
    parameter int          NUM_REGS   = 16,
    parameter int          REG_W      = 4,
    parameter int          OPC_W      = 5,
    parameter logic [31:0] LEGAL_MASK = 32'h0000_1FFF
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Run,
    input  logic                Mem_ready,
    input  logic [31:0]         IR,
    output logic                PCout,
    output logic                Zlowout,
    output logic                MDRout,
    output logic                MARin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                IncPC,
    output logic                Read,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic [OPC_W-1:0]    ALU_op,
    output logic                Done,
    output logic                Illegal
);

    // Instruction fields pack downward from bit 31: opcode, Ra, Rb, Rc.
    localparam int OPC_LSB = 32 - OPC_W;
    localparam int RA_LSB  = OPC_LSB - REG_W;
    localparam int RB_LSB  = RA_LSB - REG_W;
    localparam int RC_LSB  = RB_LSB - REG_W;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_TRAP = 4'd7
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [OPC_W-1:0]    opcode;
    logic [REG_W-1:0]    ra_idx;
    logic [REG_W-1:0]    rb_idx;
    logic [REG_W-1:0]    rc_idx;
    logic                opcode_legal;
    logic [NUM_REGS-1:0] ra_onehot;
    logic [NUM_REGS-1:0] rb_onehot;
    logic [NUM_REGS-1:0] rc_onehot;
    logic                ir_unused;

    assign opcode = IR[31:OPC_LSB];
    assign ra_idx = IR[RA_LSB +: REG_W];
    assign rb_idx = IR[RB_LSB +: REG_W];
    assign rc_idx = IR[RC_LSB +: REG_W];

    // Immediate/unused low bits of the instruction carry no control meaning.
    assign ir_unused = ^IR[RC_LSB-1:0];

    // Opcodes beyond the 32-entry mask shift out to zero and therefore trap.
    assign opcode_legal = |(LEGAL_MASK & (32'd1 << opcode));

    // Indices with no matching register produce an all-zero vector, so an
    // out-of-range destination simply writes nothing.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_decode
        assign ra_onehot[gi] = (ra_idx == REG_W'(gi));
        assign rb_onehot[gi] = (rb_idx == REG_W'(gi));
        assign rc_onehot[gi] = (rc_idx == REG_W'(gi));
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        PCout      = 1'b0;
        Zlowout    = 1'b0;
        MDRout     = 1'b0;
        MARin      = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        Rout       = '0;
        Rin        = '0;
        ALU_op     = '0;
        Done       = 1'b0;
        Illegal    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (Run) begin
                    state_next = S_T0;
                end
            end
            S_T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                Zin        = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                // PC loads only on the cycle memory data arrives, so wait
                // cycles never re-load it.
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                PCin    = Mem_ready;
                if (Mem_ready) begin
                    state_next = S_T2;
                end
            end
            S_T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                if (opcode_legal) begin
                    Rout       = rb_onehot;
                    Yin        = 1'b1;
                    state_next = S_T4;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_T4: begin
                Rout       = rc_onehot;
                Zin        = 1'b1;
                ALU_op     = opcode;
                state_next = S_T5;
            end
            S_T5: begin
                Zlowout    = 1'b1;
                Rin        = ra_onehot;
                Done       = 1'b1;
                state_next = Run ? S_T0 : S_IDLE;
            end
            S_TRAP: begin
                Illegal    = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Randomized bench for alu_rr_sequencer: an expected per-cycle trace is built
// from instruction-level rules and compared against two parameterizations.
module tb_alu_rr_sequencer;

    localparam logic [10:0] C_PCOUT   = 11'h400;
    localparam logic [10:0] C_ZLOWOUT = 11'h200;
    localparam logic [10:0] C_MDROUT  = 11'h100;
    localparam logic [10:0] C_MARIN   = 11'h080;
    localparam logic [10:0] C_PCIN    = 11'h040;
    localparam logic [10:0] C_MDRIN   = 11'h020;
    localparam logic [10:0] C_IRIN    = 11'h010;
    localparam logic [10:0] C_YIN     = 11'h008;
    localparam logic [10:0] C_ZIN     = 11'h004;
    localparam logic [10:0] C_INCPC   = 11'h002;
    localparam logic [10:0] C_READ    = 11'h001;
    localparam logic [31:0] MASK      = 32'h0000_1FFF;

    logic        Clock;
    logic        Reset_n;
    logic        Run;
    logic        Mem_ready;
    logic [31:0] IR;

    logic        PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, IncPC, Read;
    logic [15:0] Rout, Rin;
    logic [4:0]  ALU_op;
    logic        Done, Illegal;

    logic        PCout_8, Zlowout_8, MDRout_8, MARin_8, PCin_8, MDRin_8, IRin_8, Yin_8, Zin_8;
    logic        IncPC_8, Read_8;
    logic [7:0]  Rout_8, Rin_8;
    logic [4:0]  ALU_op_8;
    logic        Done_8, Illegal_8;

    int total = 0;
    int bad   = 0;
    bit inv_en = 1'b0;

    // tag: 0 idle, 1..6 T0..T5, 7 trap
    typedef struct {
        bit          run;
        bit          mrdy;
        logic [31:0] ir;
        logic [83:0] exp;
        int          tag;
    } cyc_t;

    cyc_t q[$];

    alu_rr_sequencer dut (
        .Clock(Clock), .Reset_n(Reset_n), .Run(Run), .Mem_ready(Mem_ready), .IR(IR),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .IncPC(IncPC), .Read(Read),
        .Rout(Rout), .Rin(Rin), .ALU_op(ALU_op), .Done(Done), .Illegal(Illegal)
    );

    alu_rr_sequencer #(.NUM_REGS(8), .REG_W(4)) dut8 (
        .Clock(Clock), .Reset_n(Reset_n), .Run(Run), .Mem_ready(Mem_ready), .IR(IR),
        .PCout(PCout_8), .Zlowout(Zlowout_8), .MDRout(MDRout_8), .MARin(MARin_8),
        .PCin(PCin_8), .MDRin(MDRin_8), .IRin(IRin_8), .Yin(Yin_8), .Zin(Zin_8),
        .IncPC(IncPC_8), .Read(Read_8), .Rout(Rout_8), .Rin(Rin_8), .ALU_op(ALU_op_8),
        .Done(Done_8), .Illegal(Illegal_8)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [83:0] obs();
        return {PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, IncPC, Read,
                Rout, Rin, ALU_op, Done, Illegal,
                PCout_8, Zlowout_8, MDRout_8, MARin_8, PCin_8, MDRin_8, IRin_8, Yin_8, Zin_8,
                IncPC_8, Read_8, Rout_8, Rin_8, ALU_op_8, Done_8, Illegal_8};
    endfunction

    // Expected outputs of both instances; register indices outside a file decode to zero.
    function automatic logic [83:0] mk(input logic [10:0] ctl, input int rout, input int rin,
                                       input int alu, input bit done, input bit ill);
        logic [15:0] ro16, ri16;
        logic [7:0]  ro8, ri8;
        logic [4:0]  a;
        ro16 = (rout >= 0 && rout < 16) ? (16'd1 << rout) : 16'd0;
        ri16 = (rin  >= 0 && rin  < 16) ? (16'd1 << rin)  : 16'd0;
        ro8  = (rout >= 0 && rout < 8)  ? (8'd1 << rout)  : 8'd0;
        ri8  = (rin  >= 0 && rin  < 8)  ? (8'd1 << rin)   : 8'd0;
        a    = alu[4:0];
        return {ctl, ro16, ri16, a, done, ill, ctl, ro8, ri8, a, done, ill};
    endfunction

    function automatic bit rbit();
        return ($urandom_range(0, 1) == 1);
    endfunction

    function automatic bit is_legal(input logic [31:0] ir);
        return ((MASK >> ir[31:27]) & 32'd1) != 32'd0;
    endfunction

    function automatic logic [31:0] mk_ir(input int opc, input int ra, input int rb, input int rc);
        logic [31:0] r;
        r = $urandom;
        r[31:27] = opc[4:0];
        r[26:23] = ra[3:0];
        r[22:19] = rb[3:0];
        r[18:15] = rc[3:0];
        return r;
    endfunction

    task automatic push(input bit run, input bit mrdy, input logic [31:0] ir,
                        input logic [83:0] exp, input int tag);
        cyc_t c;
        c.run = run; c.mrdy = mrdy; c.ir = ir; c.exp = exp; c.tag = tag;
        q.push_back(c);
    endtask

    task automatic add_idle(input bit run);
        push(run, rbit(), $urandom, mk(11'h000, -1, -1, 0, 1'b0, 1'b0), 0);
    endtask

    // Appends one instruction starting in T0. IR only matters from T3 on, so
    // earlier cycles carry random junk on the IR input.
    task automatic add_instr(input logic [31:0] ir, input int nwait, input bit run_last);
        int opc, ra, rb, rc;
        opc = int'(ir[31:27]);
        ra  = int'(ir[26:23]);
        rb  = int'(ir[22:19]);
        rc  = int'(ir[18:15]);
        push(rbit(), rbit(), $urandom, mk(C_PCOUT | C_MARIN | C_INCPC | C_ZIN, -1, -1, 0, 1'b0, 1'b0), 1);
        for (int k = 0; k < nwait; k++)
            push(rbit(), 1'b0, $urandom, mk(C_ZLOWOUT | C_READ | C_MDRIN, -1, -1, 0, 1'b0, 1'b0), 2);
        push(rbit(), 1'b1, $urandom, mk(C_ZLOWOUT | C_READ | C_MDRIN | C_PCIN, -1, -1, 0, 1'b0, 1'b0), 2);
        push(rbit(), rbit(), $urandom, mk(C_MDROUT | C_IRIN, -1, -1, 0, 1'b0, 1'b0), 3);
        if (is_legal(ir)) begin
            push(rbit(), rbit(), ir, mk(C_YIN, rb, -1, 0, 1'b0, 1'b0), 4);
            push(rbit(), rbit(), ir, mk(C_ZIN, rc, -1, opc, 1'b0, 1'b0), 5);
            push(run_last, rbit(), ir, mk(C_ZLOWOUT, -1, ra, 0, 1'b1, 1'b0), 6);
        end else begin
            push(rbit(), rbit(), ir, mk(11'h000, -1, -1, 0, 1'b0, 1'b0), 4);
            push(rbit(), rbit(), $urandom, mk(11'h000, -1, -1, 0, 1'b0, 1'b1), 7);
        end
    endtask

    task automatic drive(input cyc_t c);
        @(negedge Clock);
        Run       = c.run;
        Mem_ready = c.mrdy;
        IR        = c.ir;
        #1;
    endtask

    // Structural invariants checked every cycle on both instances.
    always @(negedge Clock) begin
        if (inv_en) begin
            total++;
            if ($countones(Rout) > 1 || $countones(Rin) > 1 || (Rout != 0 && Rin != 0) ||
                $countones({PCout, Zlowout, MDRout, |Rout}) > 1 || (Done && Illegal) ||
                $countones(Rout_8) > 1 || $countones(Rin_8) > 1 || (Rout_8 != 0 && Rin_8 != 0) ||
                $countones({PCout_8, Zlowout_8, MDRout_8, |Rout_8}) > 1 || (Done_8 && Illegal_8)) begin
                bad++;
                $display("FAIL invariant t=%0t Rout=%h Rin=%h Rout8=%h Rin8=%h bus=%b done/ill=%b%b",
                         $time, Rout, Rin, Rout_8, Rin_8, {PCout, Zlowout, MDRout}, Done, Illegal);
            end
        end
    end

    task automatic test_reset();
        Reset_n = 1'b0; Run = 1'b1; Mem_ready = 1'b1; IR = 32'h2891_8000;
        repeat (2) @(negedge Clock);
        #1;
        inv_en = 1'b1;
        total++;
        if (obs() !== 84'd0) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", obs(), 84'd0);
        end
        @(negedge Clock);
        Run = 1'b0;
        Reset_n = 1'b1;
        q.delete();
        repeat (3) add_idle(1'b0);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            total++;
            if (obs() !== q[i].exp) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, obs(), q[i].exp);
            end
        end
        $display("test_reset: %0d cycles", q.size());
    endtask

    task automatic test_basic();
        int t0_i, done_i;
        t0_i = -1; done_i = -1;
        q.delete();
        add_idle(1'b1);
        add_instr(32'h2891_8000, 0, 1'b0);
        add_idle(1'b0);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            total++;
            if (obs() !== q[i].exp) begin
                bad++;
                $display("FAIL basic cyc=%0d tag=%0d got=%h want=%h", i, q[i].tag, obs(), q[i].exp);
            end
            if (PCout && MARin && t0_i < 0) t0_i = i;
            if (Done && done_i < 0) done_i = i;
            if (q[i].tag == 4) begin
                total++;
                if (Rout !== 16'h0004) begin
                    bad++; $display("FAIL basic_t3_rout got=%h want=0004", Rout);
                end
            end
            if (q[i].tag == 5) begin
                total++;
                if (Rout !== 16'h0008 || ALU_op !== 5'd5) begin
                    bad++; $display("FAIL basic_t4 rout=%h alu=%0d want 0008/5", Rout, ALU_op);
                end
            end
            if (q[i].tag == 6) begin
                total++;
                if (Rin !== 16'h0002 || Done !== 1'b1) begin
                    bad++; $display("FAIL basic_t5 rin=%h done=%b want 0002/1", Rin, Done);
                end
            end
        end
        total++;
        if (t0_i < 0 || done_i < 0 || done_i - t0_i + 1 != 6) begin
            bad++;
            $display("FAIL basic_latency t0=%0d done=%0d want 6 cycles", t0_i, done_i);
        end
        $display("test_basic: IR=%h latency=%0d", 32'h2891_8000, done_i - t0_i + 1);
    endtask

    task automatic test_mem_wait();
        int t0_i, done_i, pcin_n, read_n;
        logic [31:0] ir;
        t0_i = -1; done_i = -1; pcin_n = 0; read_n = 0;
        ir = mk_ir($urandom_range(0, 12), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        q.delete();
        add_idle(1'b1);
        add_instr(ir, 3, 1'b0);
        add_idle(1'b0);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            total++;
            if (obs() !== q[i].exp) begin
                bad++;
                $display("FAIL mem_wait cyc=%0d tag=%0d got=%h want=%h", i, q[i].tag, obs(), q[i].exp);
            end
            if (PCout && MARin && t0_i < 0) t0_i = i;
            if (Done && done_i < 0) done_i = i;
            if (PCin) pcin_n++;
            if (Read && MDRin) read_n++;
        end
        total++;
        if (pcin_n != 1 || read_n != 4) begin
            bad++;
            $display("FAIL mem_wait_pulses pcin=%0d read=%0d want 1/4", pcin_n, read_n);
        end
        total++;
        if (t0_i < 0 || done_i < 0 || done_i - t0_i + 1 != 9) begin
            bad++;
            $display("FAIL mem_wait_latency t0=%0d done=%0d want 9 cycles", t0_i, done_i);
        end
        $display("test_mem_wait: IR=%h latency=%0d", ir, done_i - t0_i + 1);
    endtask

    task automatic test_illegal();
        int rin_n, ill_n;
        logic [31:0] ir;
        for (int n = 0; n < 4; n++) begin
            rin_n = 0; ill_n = 0;
            ir = mk_ir((n == 0) ? 20 : $urandom_range(13, 31),
                       $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            q.delete();
            add_idle(1'b1);
            add_instr(ir, $urandom_range(0, 1), 1'b1);
            add_idle(1'b0);
            add_idle(1'b0);
            for (int i = 0; i < q.size(); i++) begin
                drive(q[i]);
                total++;
                if (obs() !== q[i].exp) begin
                    bad++;
                    $display("FAIL illegal cyc=%0d tag=%0d got=%h want=%h", i, q[i].tag, obs(), q[i].exp);
                end
                if (Rin != 0 || Rin_8 != 0) rin_n++;
                if (Illegal) ill_n++;
            end
            total++;
            if (rin_n != 0 || ill_n != 1) begin
                bad++;
                $display("FAIL illegal_pulses rin_cycles=%0d illegal=%0d want 0/1", rin_n, ill_n);
            end
            $display("test_illegal: IR=%h opcode=%0d", ir, ir[31:27]);
        end
    endtask

    task automatic test_back_to_back();
        int done_q[$];
        logic [31:0] ir;
        q.delete();
        add_idle(1'b1);
        for (int n = 0; n < 3; n++) begin
            ir = mk_ir($urandom_range(0, 12), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            add_instr(ir, 0, (n < 2));
        end
        add_idle(1'b0);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            total++;
            if (obs() !== q[i].exp) begin
                bad++;
                $display("FAIL b2b cyc=%0d tag=%0d got=%h want=%h", i, q[i].tag, obs(), q[i].exp);
            end
            if (Done) done_q.push_back(i);
        end
        total++;
        if (done_q.size() != 3 || done_q[1] - done_q[0] != 6 || done_q[2] - done_q[1] != 6) begin
            bad++;
            $display("FAIL b2b_spacing dones=%0d want 3 pulses 6 apart", done_q.size());
        end
        $display("test_back_to_back: %0d Done pulses", done_q.size());
    endtask

    task automatic test_reg_oob();
        logic [31:0] ir;
        ir = mk_ir(3, 9, 10, 3);
        q.delete();
        add_idle(1'b1);
        add_instr(ir, 1, 1'b0);
        add_idle(1'b0);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            total++;
            if (obs() !== q[i].exp) begin
                bad++;
                $display("FAIL reg_oob cyc=%0d tag=%0d got=%h want=%h", i, q[i].tag, obs(), q[i].exp);
            end
            if (q[i].tag == 6) begin
                total++;
                if (Rin_8 !== 8'h00 || Done_8 !== 1'b1 || Rin !== 16'h0200) begin
                    bad++;
                    $display("FAIL reg_oob_t5 rin8=%h done8=%b rin16=%h want 00/1/0200", Rin_8, Done_8, Rin);
                end
            end
        end
        $display("test_reg_oob: IR=%h Ra=9", ir);
    endtask

    task automatic test_random();
        logic [31:0] ir;
        bit cont, run_last;
        cont = 1'b0;
        q.delete();
        for (int n = 0; n < 20; n++) begin
            if (!cont) begin
                repeat ($urandom_range(0, 2)) add_idle(1'b0);
                add_idle(1'b1);
            end
            ir = mk_ir(rbit() ? $urandom_range(0, 12) : $urandom_range(0, 31),
                       $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            run_last = (n < 19) && rbit();
            add_instr(ir, $urandom_range(0, 3), run_last);
            cont = is_legal(ir) && run_last;
        end
        add_idle(1'b0);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            total++;
            if (obs() !== q[i].exp) begin
                bad++;
                $display("FAIL random cyc=%0d tag=%0d ir=%h got=%h want=%h", i, q[i].tag, q[i].ir, obs(), q[i].exp);
            end
        end
        $display("test_random: %0d cycles", q.size());
    endtask

    task automatic test_reset_mid();
        int rin_n;
        logic [31:0] ir;
        rin_n = 0;
        ir = mk_ir($urandom_range(0, 12), $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
        q.delete();
        add_idle(1'b1);
        add_instr(ir, 0, 1'b1);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            total++;
            if (obs() !== q[i].exp) begin
                bad++;
                $display("FAIL reset_mid_pre cyc=%0d tag=%0d got=%h want=%h", i, q[i].tag, obs(), q[i].exp);
            end
            if (q[i].tag == 5) break;
        end
        #2;
        Reset_n = 1'b0;
        #1;
        total++;
        if (obs() !== 84'd0) begin
            bad++;
            $display("FAIL reset_mid_async got=%h want=%h", obs(), 84'd0);
        end
        repeat (2) begin
            @(negedge Clock);
            Run = 1'b1;
            #1;
            total++;
            if (obs() !== 84'd0) begin
                bad++;
                $display("FAIL reset_mid_hold got=%h want=%h", obs(), 84'd0);
            end
        end
        @(posedge Clock);
        #2;
        Reset_n = 1'b1;
        q.delete();
        add_idle(1'b1);
        add_instr(ir, 0, 1'b0);
        add_idle(1'b0);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            total++;
            if (obs() !== q[i].exp) begin
                bad++;
                $display("FAIL reset_mid_post cyc=%0d tag=%0d got=%h want=%h", i, q[i].tag, obs(), q[i].exp);
            end
            if (q[i].tag == 1 && (Rin != 0 || Rin_8 != 0)) rin_n++;
        end
        total++;
        if (rin_n != 0) begin
            bad++;
            $display("FAIL reset_mid_rin rin_cycles=%0d want 0", rin_n);
        end
        $display("test_reset_mid: IR=%h", ir);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mem_wait();
        test_illegal();
        test_back_to_back();
        test_reg_oob();
        test_random();
        test_reset_mid();
        @(negedge Clock);
        inv_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
